// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a req/ack memory read and hands each
// instruction byte to the control FSM as a one-cycle valid pulse.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        DATA_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        TIMEOUT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] data_bus,
  output logic [ADDR_W-1:0] addr_bus,
  output logic              mem_ren,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              nomem_flag
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHalt,
    StFault
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               nomem_q, nomem_d;
  logic               halt_seen_q, halt_seen_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      nomem_q     <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      nomem_q     <= nomem_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = 1'b0;
    cnt_d       = cnt_q;
    nomem_d     = nomem_q;
    halt_seen_d = halt_seen_q;
    unique case (state_q)
      StIdle: begin
        halt_seen_d = 1'b0;
        cnt_d       = '0;
        if (halt) begin
          state_d = StHalt;
        end else begin
          if (jump_en) pc_d = jump_addr;
          if (fetch_req) state_d = StReq;
        end
      end
      StReq, StWait: begin
        if (halt) halt_seen_d = 1'b1;
        if (mem_ack) begin
          instr_d = data_bus;
          pc_d    = pc_q + ADDR_W'(1);
          valid_d = 1'b1;
          cnt_d   = '0;
          // A halt raised on the ack cycle itself still counts as seen during the fetch.
          state_d = (halt || halt_seen_q) ? StHalt : StIdle;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = StFault;
          nomem_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StWait;
        end
      end
      StHalt, StFault: begin
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from state so they fall together with an async reset.
  assign mem_ren     = (state_q == StReq) || (state_q == StWait);
  assign busy        = mem_ren;
  assign addr_bus    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign nomem_flag  = nomem_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch sequences
// compared against a transaction-level PC/instruction model.
module tb_fetch_unit;

  localparam int unsigned TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_req = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = '0;
  logic       halt = 1'b0;
  logic       mem_ack = 1'b0;
  logic [7:0] data_bus = '0;
  logic [7:0] addr_bus;
  logic       mem_ren;
  logic [7:0] instr;
  logic       instr_valid;
  logic [7:0] pc;
  logic       busy;
  logic       nomem_flag;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] exp_pc;
  logic [7:0] exp_instr;

  fetch_unit #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .RESET_PC(8'h00),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .halt       (halt),
    .mem_ack    (mem_ack),
    .data_bus   (data_bus),
    .addr_bus   (addr_bus),
    .mem_ren    (mem_ren),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .nomem_flag (nomem_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one fetch from IDLE; ack arrives on the d-th REQ/WAIT cycle (0 = first).
  task automatic do_fetch(input bit jmp, input logic [7:0] ja, input int d,
                          input logic [7:0] data, input int halt_at,
                          output int ren_cycles, output int busy_cycles,
                          output logic [7:0] addr_first, output int addr_bad,
                          output bit early_valid, output bit valid_after,
                          output logic [7:0] instr_o, output logic [7:0] pc_o);
    mem_ack   = 1'b0;
    fetch_req = 1'b1;
    jump_en   = jmp;
    jump_addr = ja;
    step();
    fetch_req   = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'($urandom);
    addr_first  = addr_bus;
    ren_cycles  = 0;
    busy_cycles = 0;
    addr_bad    = 0;
    early_valid = 1'b0;
    for (int i = 0; i <= d; i++) begin
      if (mem_ren) ren_cycles++;
      if (busy) busy_cycles++;
      if (addr_bus !== addr_first) addr_bad++;
      if (instr_valid) early_valid = 1'b1;
      halt     = (i == halt_at);
      mem_ack  = (i == d);
      data_bus = (i == d) ? data : 8'($urandom);
      step();
    end
    halt        = 1'b0;
    mem_ack     = 1'b0;
    valid_after = instr_valid;
    instr_o     = instr;
    pc_o        = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    exp_pc    = 8'h00;
    exp_instr = 8'h00;
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (addr_bus !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", addr_bus); end
    checks++; if (instr !== 8'h00) begin failures++; $display("FAIL reset_instr got=%h exp=00", instr); end
    checks++; if ({mem_ren, instr_valid, busy, nomem_flag} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {mem_ren, instr_valid, busy, nomem_flag});
    end
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int rc, bc, bad; logic [7:0] a0, io, po; bit ev, va;
    do_fetch(1'b0, 8'h00, 0, 8'h3C, -1, rc, bc, a0, bad, ev, va, io, po);
    exp_instr = 8'h3C; exp_pc = exp_pc + 8'd1;
    checks++; if (va !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", va); end
    checks++; if (io !== 8'h3C) begin failures++; $display("FAIL basic_instr got=%h exp=3c", io); end
    checks++; if (po !== 8'h01) begin failures++; $display("FAIL basic_pc got=%h exp=01", po); end
    checks++; if (rc !== 1) begin failures++; $display("FAIL basic_ren_cycles got=%0d exp=1", rc); end
    step();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", instr_valid); end
    checks++; if (instr !== 8'h3C) begin failures++; $display("FAIL basic_instr_hold got=%h exp=3c", instr); end
  endtask

  task automatic test_jump_wrap();
    int rc, bc, bad; logic [7:0] a0, io, po; bit ev, va;
    do_fetch(1'b1, 8'hFF, 1, 8'hA5, -1, rc, bc, a0, bad, ev, va, io, po);
    exp_instr = 8'hA5; exp_pc = 8'h00;
    checks++; if (a0 !== 8'hFF || bad !== 0) begin
      failures++; $display("FAIL jump_addr got=%h bad=%0d exp=ff", a0, bad);
    end
    checks++; if (io !== 8'hA5) begin failures++; $display("FAIL jump_instr got=%h exp=a5", io); end
    checks++; if (po !== 8'h00) begin failures++; $display("FAIL jump_wrap_pc got=%h exp=00", po); end
    checks++; if (va !== 1'b1) begin failures++; $display("FAIL jump_valid got=%b exp=1", va); end
  endtask

  task automatic test_delayed_ack();
    int rc, bc, bad; logic [7:0] a0, io, po; bit ev, va;
    do_fetch(1'b0, 8'h00, 2, 8'h5A, -1, rc, bc, a0, bad, ev, va, io, po);
    exp_instr = 8'h5A; exp_pc = exp_pc + 8'd1;
    checks++; if (bc !== 3) begin failures++; $display("FAIL delay_busy_cycles got=%0d exp=3", bc); end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL delay_early_valid got=%b exp=0", ev); end
    checks++; if (va !== 1'b1 || io !== 8'h5A) begin
      failures++; $display("FAIL delay_result got valid=%b instr=%h exp valid=1 instr=5a", va, io);
    end
    checks++; if (nomem_flag !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL delay_nofault got nomem=%b busy=%b exp 0 0", nomem_flag, busy);
    end
  endtask

  // Back-to-back and random fetches; ack delay includes the TIMEOUT-1 boundary.
  task automatic test_random();
    int rc, bc, bad, d, gap; logic [7:0] a0, io, po, ja, dat, exp_addr; bit ev, va, jmp;
    for (int n = 0; n < 40; n++) begin
      jmp = ($urandom_range(0, 2) == 0);
      ja  = 8'($urandom);
      dat = 8'($urandom);
      d   = int'($urandom_range(0, TIMEOUT - 1));
      exp_addr = jmp ? ja : exp_pc;
      do_fetch(jmp, ja, d, dat, -1, rc, bc, a0, bad, ev, va, io, po);
      exp_pc = exp_addr + 8'd1;
      exp_instr = dat;
      checks++; if (a0 !== exp_addr || bad !== 0) begin
        failures++; $display("FAIL rand_addr n=%0d got=%h bad=%0d exp=%h", n, a0, bad, exp_addr);
      end
      checks++; if (rc !== d + 1) begin failures++; $display("FAIL rand_ren n=%0d got=%0d exp=%0d", n, rc, d + 1); end
      checks++; if (ev !== 1'b0) begin failures++; $display("FAIL rand_early_valid n=%0d got=1 exp=0", n); end
      checks++; if (va !== 1'b1) begin failures++; $display("FAIL rand_valid n=%0d got=%b exp=1", n, va); end
      checks++; if (io !== exp_instr) begin failures++; $display("FAIL rand_instr n=%0d got=%h exp=%h", n, io, exp_instr); end
      checks++; if (po !== exp_pc) begin failures++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, po, exp_pc); end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        mem_ack = $urandom_range(0, 1) == 1;  // stray acks in IDLE must be ignored
        step();
      end
      mem_ack = 1'b0;
      checks++; if (pc !== exp_pc || nomem_flag !== 1'b0) begin
        failures++; $display("FAIL rand_idle n=%0d got pc=%h nomem=%b exp pc=%h nomem=0", n, pc, nomem_flag, exp_pc);
      end
    end
  endtask

  task automatic test_halt();
    int rc, bc, bad, ren_seen, val_seen; logic [7:0] a0, io, po; bit ev, va;
    do_fetch(1'b0, 8'h00, 2, 8'hC3, 1, rc, bc, a0, bad, ev, va, io, po);
    exp_instr = 8'hC3; exp_pc = exp_pc + 8'd1;
    checks++; if (va !== 1'b1 || io !== 8'hC3) begin
      failures++; $display("FAIL halt_completes got valid=%b instr=%h exp 1 c3", va, io);
    end
    ren_seen = 0; val_seen = 0;
    fetch_req = 1'b1; jump_en = 1'b1; jump_addr = 8'h77; mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_ren || busy) ren_seen++;
      if (instr_valid) val_seen++;
    end
    fetch_req = 1'b0; jump_en = 1'b0; mem_ack = 1'b0;
    checks++; if (ren_seen !== 0 || val_seen !== 0) begin
      failures++; $display("FAIL halt_ignores got ren=%0d valid=%0d exp 0 0", ren_seen, val_seen);
    end
    checks++; if (pc !== exp_pc) begin failures++; $display("FAIL halt_pc got=%h exp=%h", pc, exp_pc); end
  endtask

  task automatic test_timeout();
    int ren_cnt, val_seen;
    ren_cnt = 0; val_seen = 0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_ren) ren_cnt++;
      step();
    end
    checks++; if (ren_cnt !== TIMEOUT) begin
      failures++; $display("FAIL timeout_ren_cycles got=%0d exp=%0d", ren_cnt, TIMEOUT);
    end
    checks++; if (nomem_flag !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_flag got nomem=%b busy=%b exp 1 0", nomem_flag, busy);
    end
    checks++; if (pc !== exp_pc) begin failures++; $display("FAIL timeout_pc got=%h exp=%h", pc, exp_pc); end
    ren_cnt = 0;
    fetch_req = 1'b1; mem_ack = 1'b1; data_bus = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_ren) ren_cnt++;
      if (instr_valid) val_seen++;
    end
    fetch_req = 1'b0; mem_ack = 1'b0;
    checks++; if (ren_cnt !== 0 || val_seen !== 0 || instr !== exp_instr) begin
      failures++; $display("FAIL fault_sticky got ren=%0d valid=%0d instr=%h exp 0 0 %h", ren_cnt, val_seen, instr, exp_instr);
    end
    checks++; if (nomem_flag !== 1'b1) begin failures++; $display("FAIL fault_flag_hold got=%b exp=1", nomem_flag); end
    #2 rst = 1'b1;
    #1;
    checks++; if (nomem_flag !== 1'b0 || pc !== 8'h00) begin
      failures++; $display("FAIL fault_reset got nomem=%b pc=%h exp 0 00", nomem_flag, pc);
    end
    step();
    #2 rst = 1'b0;
    exp_pc = 8'h00; exp_instr = 8'h00;
    step();
  endtask

  task automatic test_reset_mid_wait();
    jump_en = 1'b1; jump_addr = 8'h42; fetch_req = 1'b1;
    step();
    jump_en = 1'b0; fetch_req = 1'b0;
    step();
    checks++; if (mem_ren !== 1'b1 || addr_bus !== 8'h42) begin
      failures++; $display("FAIL rstwait_pre got ren=%b addr=%h exp 1 42", mem_ren, addr_bus);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_ren, busy, instr_valid, nomem_flag} !== 4'b0000 || pc !== 8'h00) begin
      failures++; $display("FAIL rstwait_async got flags=%b pc=%h exp 0000 00",
                           {mem_ren, busy, instr_valid, nomem_flag}, pc);
    end
    step();
    #2 rst = 1'b0;
    step();
  endtask

  initial begin
    exp_pc = 8'h00;
    exp_instr = 8'h00;
    test_reset();
    test_basic();
    test_jump_wrap();
    test_delayed_ack();
    test_random();
    test_halt();
    test_reset();
    test_timeout();
    test_reset_mid_wait();
    test_basic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
